// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default framing constants.
package uart_pkg;

   localparam int unsigned DEFAULT_DATA_BITS  = 8;
   localparam int unsigned DEFAULT_OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake and error pulses between uart_rx (master) and its consumer (slave).
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
);

   logic [DATA_BITS-1:0] dout;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun_err;

   modport master (
      output dout,
      output rx_valid,
      output frame_err,
      output overrun_err,
      input  rx_ready
   );

   modport slave (
      input  dout,
      input  rx_valid,
      input  frame_err,
      input  overrun_err,
      output rx_ready
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first data, stop-bit check,
// one-deep output register with valid/ready handshake, frame and overrun error pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      tick,
   input  logic      rx,
   uart_rx_if.master bus
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS) + 1;

   localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   logic rx_s;

   uart_state_e          state, state_nxt;
   logic [CW-1:0]        tcnt, tcnt_nxt;
   logic [BW-1:0]        bidx, bidx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;

   logic stop_done;
   logic load;
   logic frame;
   logic overrun;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         tcnt            <= '0;
         bidx            <= '0;
         shreg           <= '0;
         bus.dout        <= '0;
         bus.rx_valid    <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.overrun_err <= 1'b0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
         bidx  <= bidx_nxt;
         shreg <= shreg_nxt;
         if (load) begin
            bus.dout <= shreg;
         end
         // A load in the handshake cycle keeps valid high with the fresh byte.
         bus.rx_valid    <= load | (bus.rx_valid & ~bus.rx_ready);
         bus.frame_err   <= frame;
         bus.overrun_err <= overrun;
      end
   end

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      bidx_nxt  = bidx;
      shreg_nxt = shreg;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nxt = START;
                  tcnt_nxt  = '0;
               end
            end
            START: begin
               if (tcnt == MID_TICK) begin
                  tcnt_nxt  = '0;
                  bidx_nxt  = '0;
                  state_nxt = rx_s ? IDLE : DATA;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            DATA: begin
               if (tcnt == LAST_TICK) begin
                  shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                  tcnt_nxt  = '0;
                  bidx_nxt  = bidx + 1'b1;
                  if (bidx == LAST_BIT) begin
                     state_nxt = STOP;
                  end
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            STOP: begin
               // Leave at mid-stop-bit so a back-to-back start edge is not missed.
               if (tcnt == LAST_TICK) begin
                  state_nxt = IDLE;
                  tcnt_nxt  = '0;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stop_done = tick && (state == STOP) && (tcnt == LAST_TICK);
      load      = stop_done && rx_s && (!bus.rx_valid || bus.rx_ready);
      frame     = stop_done && !rx_s;
      overrun   = stop_done && rx_s && bus.rx_valid && !bus.rx_ready;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, tick pulses per bit period; power of two, ≥8.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick  input  1  baud-oversample strobe, one clk wide, OVERSAMPLE per bit.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port dout  output  DATA_BITS  received byte, LSB received first.
REQ-008 SHALL have port rx_valid  output  1  dout holds an unconsumed byte.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts dout when rx_valid && rx_ready.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 SHALL have port overrun_err  output  1  one-clk pulse: good frame completed while rx_valid high.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 SHALL implement states IDLE, START, DATA, STOP; all counters advance only on clk edges where tick=1.
REQ-014 IDLE: on tick with rx_s=0 SHALL go to START, clear tick counter.
REQ-015 START: at tick counter = OVERSAMPLE/2-1 SHALL go to DATA with counters cleared if rx_s=0, else return to IDLE (glitch rejected, no error).
REQ-016 DATA: at tick counter = OVERSAMPLE-1 SHALL shift rx_s into the MSB of the shift register (LSB-first), clear tick counter, increment bit index.
REQ-017 DATA: after sampling bit DATA_BITS-1 SHALL go to STOP.
REQ-018 STOP: at tick counter = OVERSAMPLE-1 SHALL sample rx_s and go to IDLE in the same cycle (mid-stop-bit, so the next start edge is caught).
REQ-019 Stop sample 1 and rx_valid=0 (or handshake this cycle) SHALL load dout from shift register and set rx_valid next clk.
REQ-020 Stop sample 0 SHALL pulse frame_err one clk; dout and rx_valid unchanged.
REQ-021 Stop sample 1 while rx_valid=1 and rx_ready=0 SHALL pulse overrun_err one clk, drop new byte, keep old dout.
REQ-022 rx_valid SHALL clear on the clk after rx_valid && rx_ready, unless a new byte loads that same cycle (then stays 1 with new dout).
REQ-023 dout SHALL remain stable while rx_valid=1.
REQ-024 Tick counter width SHALL be $clog2(OVERSAMPLE); bit index width $clog2(DATA_BITS)+1; no wrap before terminal value.
REQ-025 Latency: rx_valid SHALL rise 1 clk after the tick edge that samples mid-stop-bit.
REQ-026 A break (rx low indefinitely) SHALL yield one frame_err per frame time, never rx_valid.

Reset
REQ-027 rst_n low SHALL force state IDLE, counters 0, shift register 0, dout 0, rx_valid 0, frame_err 0, overrun_err 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the partial byte; reception restarts on the next falling edge after release.

Structure
REQ-029 State enum and default OVERSAMPLE/DATA_BITS constants SHALL live in shared package uart_pkg, used by uart_tx and uart_rx.
REQ-030 Synchronizer SHALL be sub-module sync_2ff (async active-low reset, reset value parameterized).
REQ-031 Implementation SHALL be one sequential process plus one next-state combinational process; no latches.

Verification
REQ-032 Frame 0xA5, good stop, rx_ready=1 -> dout=0xA5, rx_valid high one clk, no error pulses.
REQ-033 rx low for 4 ticks then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-034 Frame 0x3C with stop bit low -> frame_err pulse once, rx_valid stays 0.
REQ-035 Frames 0x11 then 0x22, rx_ready=0 -> dout=0x11, rx_valid=1, overrun_err pulse at end of second frame.
REQ-036 Loopback from uart_tx, back-to-back 0x00, 0xFF, 0x55 -> three bytes in order, zero errors.
REQ-037 rst_n asserted during bit 3 of 0x81, then clean frame 0x42 -> only 0x42 delivered.
